// File: rtl/pc_pkg.sv
// Shared types and alignment helpers for the IF-stage program-counter unit.
package pc_pkg;

  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_HOLD = 1'b1
  } pc_state_e;

  function automatic int unsigned stepLog2(input int unsigned step);
    int unsigned n;
    n = 0;
    while ((64'(1) << n) < 64'(step)) n++;
    return n;
  endfunction

  function automatic logic [63:0] alignMask(input int unsigned step);
    return 64'(step) - 64'd1;
  endfunction

  function automatic bit isPow2(input int unsigned step);
    return (step != 0) && ((64'(1) << stepLog2(step)) == 64'(step));
  endfunction

endpackage

// File: rtl/pc_if.sv
// Control/response bundle between the hazard/branch logic (master) and the PC unit (slave).
interface pc_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_tgt;
  logic             exc_req;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_next_seq;
  logic             valid_out;
  logic             flush;
  logic             pending;
  logic             misalign_err;

  modport master (
    output stall, redirect, redirect_tgt, exc_req,
    input  pc_out, pc_next_seq, valid_out, flush, pending, misalign_err
  );

  modport slave (
    input  stall, redirect, redirect_tgt, exc_req,
    output pc_out, pc_next_seq, valid_out, flush, pending, misalign_err
  );
endinterface

// File: rtl/pc_align_chk.sv
// Combinational check that a redirect target is STEP-aligned; STEP=1 yields an all-zero mask.
module pc_align_chk
  import pc_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic [WIDTH-1:0] tgt_i,
  output logic             misaligned_o
);
  localparam logic [63:0]      MASK64 = alignMask(STEP);
  localparam logic [WIDTH-1:0] MASK   = MASK64[WIDTH-1:0];

  assign misaligned_o = |(tgt_i & MASK);
endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: sequential increment, stall, branch redirect (buffered while stalled)
// and exception redirect, with registered flush/misalign pulses.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80)
) (
  input logic  clk_i,
  input logic  rst_i,
  pc_if.slave  bus
);
  localparam logic [63:0]      MASK64 = alignMask(STEP);
  localparam logic [WIDTH-1:0] MASK   = MASK64[WIDTH-1:0];

  if (WIDTH < 8) begin : g_bad_width
    $error("pc_unit: WIDTH must be at least 8");
  end
  if (!isPow2(STEP)) begin : g_bad_step
    $error("pc_unit: STEP must be a power of two");
  end
  if (((RESET_VECTOR & MASK) != '0) || ((EXC_VECTOR & MASK) != '0)) begin : g_bad_vec
    $error("pc_unit: reset/exception vectors must be STEP-aligned");
  end

  pc_state_e        state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] buf_q;
  logic             valid_q;
  logic             flush_q;
  logic             misalign_q;
  logic [WIDTH-1:0] pc_d;
  logic             tgt_misaligned;

  pc_align_chk #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_align (
    .tgt_i        (bus.redirect_tgt),
    .misaligned_o (tgt_misaligned)
  );

  assign pc_d = pc_q + WIDTH'(STEP);

  // Priority chain: exception, misaligned redirect, redirect, buffered redirect, stall, increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= PC_RUN;
      pc_q       <= RESET_VECTOR;
      buf_q      <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= 1'b1;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      if (bus.exc_req) begin
        pc_q    <= EXC_VECTOR;
        flush_q <= 1'b1;
        state_q <= PC_RUN;
        buf_q   <= '0;
      end else if (bus.redirect && tgt_misaligned) begin
        pc_q       <= EXC_VECTOR;
        flush_q    <= 1'b1;
        misalign_q <= 1'b1;
        state_q    <= PC_RUN;
        buf_q      <= '0;
      end else if (bus.redirect && !bus.stall) begin
        pc_q    <= bus.redirect_tgt;
        flush_q <= 1'b1;
        state_q <= PC_RUN;
      end else if (bus.redirect) begin
        buf_q   <= bus.redirect_tgt;
        state_q <= PC_HOLD;
      end else if (state_q == PC_HOLD && !bus.stall) begin
        pc_q    <= buf_q;
        flush_q <= 1'b1;
        state_q <= PC_RUN;
      end else if (!bus.stall) begin
        pc_q <= pc_d;
      end
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.pc_next_seq  = pc_d;
  assign bus.valid_out    = valid_q;
  assign bus.flush        = flush_q;
  assign bus.pending      = (state_q == PC_HOLD);
  assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (WIDTH=32, STEP=4): directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch PC.
module tb_pc_unit;
  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  pc_if #(.WIDTH(32)) bus ();

  pc_unit #(
    .WIDTH        (32),
    .STEP         (4),
    .RESET_VECTOR (32'h0),
    .EXC_VECTOR   (32'h80)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  longint unsigned mPc;
  longint unsigned mBuf;
  bit              mPending;
  bit              mValid;
  bit              mFlush;
  bit              mMis;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  task automatic modelEdge();
    longint unsigned tgt;
    tgt    = longint'(bus.redirect_tgt);
    mFlush = 0;
    mMis   = 0;
    if (rst) begin
      mPc = 0; mBuf = 0; mPending = 0; mValid = 0;
    end else begin
      mValid = 1;
      if (bus.exc_req) begin
        mPc = 'h80; mFlush = 1; mPending = 0;
      end else if (bus.redirect && (tgt % 4 != 0)) begin
        mPc = 'h80; mFlush = 1; mMis = 1; mPending = 0;
      end else if (bus.redirect && !bus.stall) begin
        mPc = tgt; mFlush = 1; mPending = 0;
      end else if (bus.redirect) begin
        mBuf = tgt; mPending = 1;
      end else if (mPending && !bus.stall) begin
        mPc = mBuf; mFlush = 1; mPending = 0;
      end else if (!bus.stall) begin
        mPc = (mPc + 4) % MOD;
      end
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd,
                       input logic [31:0] t, input logic e);
    rst              = r;
    bus.stall        = s;
    bus.redirect     = rd;
    bus.redirect_tgt = t;
    bus.exc_req      = e;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 32'h0, 0);
    tick(); tick();
    checks++; if (bus.pc_out !== 32'h0) $display("[TB] FAIL reset_pc: got %h want %h", bus.pc_out, 32'h0); else passes++;
    checks++; if (bus.valid_out !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", bus.valid_out); else passes++;
    checks++; if ({bus.flush, bus.pending, bus.misalign_err} !== 3'b000)
      $display("[TB] FAIL reset_flags: got %b want 000", {bus.flush, bus.pending, bus.misalign_err}); else passes++;
    drive(0, 0, 0, 32'h0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.pc_out !== 32'(4 * i)) $display("[TB] FAIL seq_pc%0d: got %h want %h", i, bus.pc_out, 32'(4 * i)); else passes++;
      checks++; if (bus.valid_out !== 1'b1) $display("[TB] FAIL seq_valid%0d: got %b want 1", i, bus.valid_out); else passes++;
    end
    checks++; if (bus.pc_next_seq !== 32'h10) $display("[TB] FAIL next_seq: got %h want %h", bus.pc_next_seq, 32'h10); else passes++;
  endtask

  task automatic test_redirect();
    drive(1, 0, 0, 32'h0, 0); tick();
    drive(0, 0, 0, 32'h0, 0); tick(); tick();
    checks++; if (bus.pc_out !== 32'h8) $display("[TB] FAIL redir_setup: got %h want %h", bus.pc_out, 32'h8); else passes++;
    drive(0, 0, 1, 32'h100, 0); tick();
    checks++; if (bus.pc_out !== 32'h100 || bus.flush !== 1'b1)
      $display("[TB] FAIL redir_take: got pc=%h flush=%b want pc=100 flush=1", bus.pc_out, bus.flush); else passes++;
    drive(0, 0, 0, 32'h0, 0); tick();
    checks++; if (bus.pc_out !== 32'h104 || bus.flush !== 1'b0)
      $display("[TB] FAIL redir_after: got pc=%h flush=%b want pc=104 flush=0", bus.pc_out, bus.flush); else passes++;
  endtask

  task automatic test_stall_buffer();
    logic [31:0] held;
    held = bus.pc_out;
    drive(0, 1, 1, 32'h200, 0); tick();
    drive(0, 1, 1, 32'h300, 0); tick();
    drive(0, 1, 0, 32'h0, 0);   tick();
    checks++; if (bus.pc_out !== held || bus.pending !== 1'b1 || bus.flush !== 1'b0)
      $display("[TB] FAIL stall_hold: got pc=%h pend=%b flush=%b want pc=%h pend=1 flush=0",
               bus.pc_out, bus.pending, bus.flush, held); else passes++;
    drive(0, 0, 0, 32'h0, 0); tick();
    checks++; if (bus.pc_out !== 32'h300 || bus.flush !== 1'b1 || bus.pending !== 1'b0)
      $display("[TB] FAIL stall_release: got pc=%h flush=%b pend=%b want pc=300 flush=1 pend=0",
               bus.pc_out, bus.flush, bus.pending); else passes++;
  endtask

  task automatic test_exception();
    drive(0, 1, 1, 32'h400, 0); tick();
    checks++; if (bus.pending !== 1'b1) $display("[TB] FAIL exc_setup: got pend=%b want 1", bus.pending); else passes++;
    drive(0, 1, 0, 32'h0, 1); tick();
    checks++; if (bus.pc_out !== 32'h80 || bus.flush !== 1'b1 || bus.pending !== 1'b0)
      $display("[TB] FAIL exc_take: got pc=%h flush=%b pend=%b want pc=80 flush=1 pend=0",
               bus.pc_out, bus.flush, bus.pending); else passes++;
    drive(0, 0, 0, 32'h0, 0); tick();
    checks++; if (bus.pc_out !== 32'h84 || bus.flush !== 1'b0)
      $display("[TB] FAIL exc_after: got pc=%h flush=%b want pc=84 flush=0", bus.pc_out, bus.flush); else passes++;
  endtask

  task automatic test_misalign();
    drive(0, 0, 1, 32'h102, 0); tick();
    checks++; if (bus.pc_out !== 32'h80 || bus.misalign_err !== 1'b1 || bus.flush !== 1'b1)
      $display("[TB] FAIL misalign_take: got pc=%h mis=%b flush=%b want pc=80 mis=1 flush=1",
               bus.pc_out, bus.misalign_err, bus.flush); else passes++;
    drive(0, 0, 0, 32'h0, 0); tick();
    checks++; if (bus.misalign_err !== 1'b0 || bus.flush !== 1'b0 || bus.pc_out !== 32'h84)
      $display("[TB] FAIL misalign_pulse: got pc=%h mis=%b flush=%b want pc=84 mis=0 flush=0",
               bus.pc_out, bus.misalign_err, bus.flush); else passes++;
  endtask

  task automatic test_wrap_and_reset_hold();
    drive(0, 0, 1, 32'hFFFF_FFF8, 0); tick();
    drive(0, 0, 0, 32'h0, 0); tick();
    checks++; if (bus.pc_out !== 32'hFFFF_FFFC || bus.pc_next_seq !== 32'h0)
      $display("[TB] FAIL wrap_setup: got pc=%h nseq=%h want pc=fffffffc nseq=0", bus.pc_out, bus.pc_next_seq); else passes++;
    tick();
    checks++; if (bus.pc_out !== 32'h0 || bus.misalign_err !== 1'b0 || bus.flush !== 1'b0)
      $display("[TB] FAIL wrap: got pc=%h mis=%b flush=%b want pc=0 mis=0 flush=0",
               bus.pc_out, bus.misalign_err, bus.flush); else passes++;
    drive(0, 0, 0, 32'h0, 0); tick(); tick();
    drive(0, 1, 1, 32'h500, 0); tick();
    checks++; if (bus.pending !== 1'b1) $display("[TB] FAIL hold_setup: got pend=%b want 1", bus.pending); else passes++;
    drive(1, 1, 1, 32'h600, 1); tick();
    checks++; if (bus.pc_out !== 32'h0 || bus.pending !== 1'b0 || bus.valid_out !== 1'b0 || bus.flush !== 1'b0)
      $display("[TB] FAIL reset_in_hold: got pc=%h pend=%b valid=%b flush=%b want pc=0 pend=0 valid=0 flush=0",
               bus.pc_out, bus.pending, bus.valid_out, bus.flush); else passes++;
    drive(0, 0, 0, 32'h0, 0); tick();
    checks++; if (bus.pc_out !== 32'h4 || bus.flush !== 1'b0)
      $display("[TB] FAIL reset_in_hold_after: got pc=%h flush=%b want pc=4 flush=0", bus.pc_out, bus.flush); else passes++;
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            t, ($urandom_range(0, 15) == 0));
      tick();
      checks++; if (bus.pc_out !== 32'(mPc)) $display("[TB] FAIL rnd_pc@%0d: got %h want %h", i, bus.pc_out, 32'(mPc)); else passes++;
      checks++; if (bus.pc_next_seq !== 32'((mPc + 4) % MOD))
        $display("[TB] FAIL rnd_nseq@%0d: got %h want %h", i, bus.pc_next_seq, 32'((mPc + 4) % MOD)); else passes++;
      checks++; if ({bus.valid_out, bus.flush, bus.pending, bus.misalign_err} !== {mValid, mFlush, mPending, mMis})
        $display("[TB] FAIL rnd_flags@%0d: got %b want %b", i,
                 {bus.valid_out, bus.flush, bus.pending, bus.misalign_err}, {mValid, mFlush, mPending, mMis}); else passes++;
    end
  endtask

  initial begin
    drive(1, 0, 0, 32'h0, 0);
    mPc = 0; mBuf = 0; mPending = 0; mValid = 0; mFlush = 0; mMis = 0;
    test_reset();
    test_redirect();
    test_stall_buffer();
    test_exception();
    test_misalign();
    test_wrap_and_reset_hold();
    drive(1, 0, 0, 32'h0, 0); tick();
    test_random();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
